silife_uart_loader: RTL and testbench

Serial pattern loader that sits directly upstream of the 8x32 life grid's row-write port. It receives a framed bitmap over a UART line (8N1, LSB first), and writes each received byte into the grid as one row. It also drives a hold signal so the top level can freeze generation stepping while a frame is in flight. It is an alternative write source to the switch/uio path and the demo sequencer, and is muxed into the grid's `row_select` / `set_cells` / `clear_cells` the same way.

---
 rtl/silife_pkg.sv | 27 ++
 rtl/silife_uart_rx.sv | 111 +++++++++++
 rtl/silife_uart_loader.sv | 120 ++++++++++++
 tb/tb_silife_uart_loader.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/silife_pkg.sv
// silife_pkg: shared constants and state encodings for the life-grid
// pattern loader.
//   GRID_WIDTH / GRID_HEIGHT : grid geometry (cells per row, rows)
//   ROW_W                    : width of a row index
//   SYNC_BYTE_DEFAULT        : default frame header byte
package silife_pkg;

  localparam int GRID_WIDTH  = 8;
  localparam int GRID_HEIGHT = 32;
  localparam int ROW_W       = 5;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  typedef enum logic [1:0] {
    F_SYNC,
    F_ROWS,
    F_CHECK
  } frame_state_t;

endpackage

// File: rtl/silife_uart_rx.sv
// silife_uart_rx: 8N1 UART receiver, LSB first.
//   clk, reset    : clock, synchronous active-high reset
//   i_enable      : low holds the receiver idle
//   i_rx          : asynchronous serial input, idle high
//   o_byte        : received byte, valid with o_valid
//   o_valid       : one-cycle strobe for a byte with a good stop bit
//   o_frame_err   : one-cycle strobe when the stop bit samples low
//
// state    | meaning
// ---------+-------------------------------------------------
// RX_IDLE  | waiting for a falling edge on the synchronized line
// RX_START | half-bit wait, confirm start bit is still low
// RX_DATA  | sampling 8 data bits, one per bit period
// RX_STOP  | sampling the stop bit, then straight back to idle
module silife_uart_rx
  import silife_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_enable,
  input  logic       i_rx,
  output logic [7:0] o_byte,
  output logic       o_valid,
  output logic       o_frame_err
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

  rx_state_t        state;
  logic [1:0]       sync;
  logic             rx_prev;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;
  logic             rx_s;

  assign rx_s = sync[1];

  always_ff @(posedge clk) begin
    if (reset) begin
      sync        <= 2'b11;
      rx_prev     <= 1'b1;
      state       <= RX_IDLE;
      cnt         <= '0;
      bit_idx     <= '0;
      shreg       <= '0;
      o_byte      <= '0;
      o_valid     <= 1'b0;
      o_frame_err <= 1'b0;
    end else begin
      sync        <= {sync[0], i_rx};
      rx_prev     <= rx_s;
      o_valid     <= 1'b0;
      o_frame_err <= 1'b0;
      if (!i_enable) begin
        state <= RX_IDLE;
      end else begin
        case (state)
          RX_IDLE: begin
            // Edge rather than level, so a line left low after a framing
            // error does not immediately retrigger a start.
            if (rx_prev && !rx_s) begin
              state <= RX_START;
              cnt   <= HALF_M1;
            end
          end
          RX_START: begin
            if (cnt != '0) begin
              cnt <= cnt - CNT_W'(1);
            end else if (!rx_s) begin
              state   <= RX_DATA;
              cnt     <= FULL_M1;
              bit_idx <= '0;
            end else begin
              state <= RX_IDLE;
            end
          end
          RX_DATA: begin
            if (cnt != '0) begin
              cnt <= cnt - CNT_W'(1);
            end else begin
              shreg   <= {rx_s, shreg[7:1]};
              cnt     <= FULL_M1;
              bit_idx <= bit_idx + 3'd1;
              if (bit_idx == 3'd7) state <= RX_STOP;
            end
          end
          RX_STOP: begin
            if (cnt != '0) begin
              cnt <= cnt - CNT_W'(1);
            end else begin
              state <= RX_IDLE;
              if (rx_s) begin
                o_valid <= 1'b1;
                o_byte  <= shreg;
              end else begin
                o_frame_err <= 1'b1;
              end
            end
          end
          default: state <= RX_IDLE;
        endcase
      end
    end
  end

endmodule

// File: rtl/silife_uart_loader.sv
// silife_uart_loader: receives a framed bitmap over UART and writes it into
// the life grid one row per byte. Frame = SYNC_BYTE, GRID_HEIGHT row bytes,
// XOR checksum of the row bytes.
//   clk, reset     : clock, synchronous active-high reset
//   i_enable       : low idles the receiver and silently aborts a frame
//   i_rx           : asynchronous UART input, idle high
//   o_row_select   : row being written (held until the next write)
//   o_cells        : row data, bit 7 = leftmost cell (held until next write)
//   o_wr_en        : one-cycle row write strobe
//   o_hold         : high while a frame is in progress
//   o_frame_done   : one-cycle pulse on a frame with a good checksum
//   o_frame_error  : one-cycle pulse on checksum, framing or timeout failure
//
// state   | meaning
// --------+----------------------------------------------------
// F_SYNC  | hunting for SYNC_BYTE, other bytes and errors ignored
// F_ROWS  | each byte is written as the next row
// F_CHECK | next byte is compared with the running checksum
module silife_uart_loader
  import silife_pkg::*;
#(
  parameter int                    CLKS_PER_BIT   = 434,
  parameter int                    TIMEOUT_CYCLES = 1048576,
  parameter logic [GRID_WIDTH-1:0] SYNC_BYTE      = SYNC_BYTE_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_enable,
  input  logic                  i_rx,
  output logic [ROW_W-1:0]      o_row_select,
  output logic [GRID_WIDTH-1:0] o_cells,
  output logic                  o_wr_en,
  output logic                  o_hold,
  output logic                  o_frame_done,
  output logic                  o_frame_error
);

  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT_CYCLES);

  logic [7:0]            rx_byte;
  logic                  rx_valid;
  logic                  rx_frame_err;

  frame_state_t          fstate;
  logic [ROW_W-1:0]      row;
  logic [GRID_WIDTH-1:0] csum;
  logic [TMR_W-1:0]      tmr;

  silife_uart_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk        (clk),
    .reset      (reset),
    .i_enable   (i_enable),
    .i_rx       (i_rx),
    .o_byte     (rx_byte),
    .o_valid    (rx_valid),
    .o_frame_err(rx_frame_err)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      fstate        <= F_SYNC;
      row           <= '0;
      csum          <= '0;
      tmr           <= '0;
      o_row_select  <= '0;
      o_cells       <= '0;
      o_wr_en       <= 1'b0;
      o_hold        <= 1'b0;
      o_frame_done  <= 1'b0;
      o_frame_error <= 1'b0;
    end else begin
      o_wr_en       <= 1'b0;
      o_frame_done  <= 1'b0;
      o_frame_error <= 1'b0;
      if (!i_enable) begin
        fstate <= F_SYNC;
        row    <= '0;
        o_hold <= 1'b0;
      end else if (fstate == F_SYNC) begin
        if (rx_valid && rx_byte == SYNC_BYTE) begin
          fstate <= F_ROWS;
          row    <= '0;
          csum   <= '0;
          tmr    <= TMR_LOAD;
          o_hold <= 1'b1;
        end
      end else begin
        // A byte arriving on the timeout cycle takes priority.
        if (rx_valid) begin
          tmr <= TMR_LOAD;
          if (fstate == F_ROWS) begin
            o_wr_en      <= 1'b1;
            o_row_select <= row;
            o_cells      <= rx_byte;
            csum         <= csum ^ rx_byte;
            row          <= row + ROW_W'(1);
            if (row == ROW_W'(GRID_HEIGHT - 1)) fstate <= F_CHECK;
          end else begin
            if (rx_byte == csum) o_frame_done  <= 1'b1;
            else                 o_frame_error <= 1'b1;
            fstate <= F_SYNC;
            row    <= '0;
            o_hold <= 1'b0;
          end
        end else if (rx_frame_err || tmr == TMR_W'(1)) begin
          o_frame_error <= 1'b1;
          fstate        <= F_SYNC;
          row           <= '0;
          o_hold        <= 1'b0;
        end else begin
          tmr <= tmr - TMR_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_silife_uart_loader.sv
module tb_silife_uart_loader;

  localparam int CPB = 4;
  localparam int TMO = 200;
  localparam int K_WR = 0;
  localparam int K_DONE = 1;
  localparam int K_ERR = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       i_enable = 1'b1;
  logic       i_rx = 1'b1;
  logic [4:0] o_row_select;
  logic [7:0] o_cells;
  logic       o_wr_en;
  logic       o_hold;
  logic       o_frame_done;
  logic       o_frame_error;

  silife_uart_loader #(
    .CLKS_PER_BIT  (CPB),
    .TIMEOUT_CYCLES(TMO),
    .SYNC_BYTE     (8'hA5)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .i_enable     (i_enable),
    .i_rx         (i_rx),
    .o_row_select (o_row_select),
    .o_cells      (o_cells),
    .o_wr_en      (o_wr_en),
    .o_hold       (o_hold),
    .o_frame_done (o_frame_done),
    .o_frame_error(o_frame_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         kind;
    logic [4:0] row;
    logic [7:0] cells;
    bit         tmo;
  } ev_t;

  ev_t exp_q[$];
  int  total = 0;
  int  bad = 0;
  int  cyc = 0;
  int  last_wr_cyc = 0;
  int  act_kind;
  ev_t cur;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents an event.
  always @(negedge clk) begin
    if (!reset && (o_wr_en || o_frame_done || o_frame_error)) begin
      check("single_event", int'(o_wr_en) + int'(o_frame_done) + int'(o_frame_error), 1);
      act_kind = o_wr_en ? K_WR : (o_frame_done ? K_DONE : K_ERR);
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_event: got kind %0d expected none (cycle %0d)", act_kind, cyc);
      end else begin
        cur = exp_q.pop_front();
        check("event_kind", act_kind, cur.kind);
        if (cur.kind == K_WR) begin
          check("wr_row", o_row_select, cur.row);
          check("wr_cells", o_cells, cur.cells);
          check("hold_during_wr", o_hold, 1);
          last_wr_cyc = cyc;
        end else begin
          check("hold_at_end", o_hold, 0);
          if (cur.tmo) check("timeout_delay", cyc - last_wr_cyc, TMO);
        end
      end
    end
  end

  task automatic push_ev(input int kind, input int row, input int cells, input bit tmo);
    ev_t e;
    e.kind  = kind;
    e.row   = 5'(row);
    e.cells = 8'(cells);
    e.tmo   = tmo;
    exp_q.push_back(e);
  endtask

  task automatic send_bit(input logic v);
    i_rx = v;
    repeat (CPB) @(posedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(stop);
    i_rx = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic send_rows(input int n);
    for (int k = 0; k < n; k++) begin
      push_ev(K_WR, k, k + 1, 1'b0);
      send_byte(8'(k + 1), 1'b1);
    end
  endtask

  task automatic send_frame(input logic [7:0] cs, input int kind);
    send_byte(8'hA5, 1'b1);
    send_rows(32);
    push_ev(kind, 0, 0, 1'b0);
    send_byte(cs, 1'b1);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 2000 && exp_q.size() != 0; i++) @(posedge clk);
    repeat (4) @(posedge clk);
    #1;
    check(name, exp_q.size(), 0);
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_row"}, o_row_select, 0);
    check({name, "_cells"}, o_cells, 0);
    check({name, "_wr"}, o_wr_en, 0);
    check({name, "_hold"}, o_hold, 0);
    check({name, "_done"}, o_frame_done, 0);
    check({name, "_err"}, o_frame_error, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish by 1ms");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    reset = 1'b0;
    repeat (5) @(posedge clk);

    // Sync filtering: non-sync bytes and a one-cycle glitch do nothing.
    send_byte(8'h00, 1'b1);
    send_byte(8'hFF, 1'b1);
    i_rx = 1'b0;
    @(posedge clk);
    i_rx = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("filter_hold", o_hold, 0);
    send_byte(8'hA5, 1'b1);
    #1;
    check("hold_after_sync", o_hold, 1);
    send_rows(32);
    push_ev(K_DONE, 0, 0, 1'b0);
    send_byte(8'h20, 1'b1);
    drain("good_frame_drain");

    // Bad checksum.
    send_frame(8'h00, K_ERR);
    drain("bad_cs_drain");
    check("bad_cs_hold", o_hold, 0);

    // Framing error on row 5, trailing bytes ignored, then a good frame.
    send_byte(8'hA5, 1'b1);
    send_rows(5);
    push_ev(K_ERR, 0, 0, 1'b0);
    send_byte(8'h06, 1'b0);
    repeat (10) @(posedge clk);
    drain("framing_drain");
    check("framing_hold", o_hold, 0);
    send_byte(8'h07, 1'b1);
    send_byte(8'h08, 1'b1);
    send_frame(8'h20, K_DONE);
    drain("after_framing_drain");

    // Timeout after 3 rows, then a frame restarting at row 0.
    send_byte(8'hA5, 1'b1);
    send_rows(3);
    push_ev(K_ERR, 0, 0, 1'b1);
    repeat (250) @(posedge clk);
    drain("timeout_drain");
    check("timeout_hold", o_hold, 0);
    send_frame(8'h20, K_DONE);
    drain("after_timeout_drain");

    // Reset after row 10.
    send_byte(8'hA5, 1'b1);
    send_rows(11);
    drain("pre_reset_drain");
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_all_zero("mid_reset");
    reset = 1'b0;
    repeat (3) @(posedge clk);
    send_frame(8'h20, K_DONE);
    drain("after_reset_drain");

    // Enable dropped mid-frame: silent abort.
    send_byte(8'hA5, 1'b1);
    send_rows(2);
    drain("pre_disable_drain");
    i_enable = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("disable_hold", o_hold, 0);
    i_enable = 1'b1;
    repeat (3) @(posedge clk);
    send_frame(8'h20, K_DONE);
    drain("final_drain");

    repeat (20) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
